// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: registers rd and CSR write data, steers redirects, and
// folds exceptions and interrupts into a single precise trap with a drain period.
module wb_commit_unit #(
  parameter int XLEN       = 64,
  parameter int REG_AW     = 5,
  parameter int TRAP_STALL = 2,
  parameter int CNT_W      = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WB_V,
  input  logic [31:0]       WB_IR,
  input  logic [XLEN-1:0]   WB_PC,
  input  logic [XLEN-1:0]   WB_NPC,
  input  logic [XLEN-1:0]   WB_MEM_RESULT,
  input  logic [XLEN-1:0]   WB_ALU_RESULT,
  input  logic [XLEN-1:0]   WB_RFD,
  input  logic [XLEN-1:0]   WB_CSRFD,
  input  logic [REG_AW-1:0] WB_DRID,
  input  logic              MEM_PC_MUX,
  input  logic              F_IAM,
  input  logic              F_IAF,
  input  logic              F_II,
  input  logic              WB_ECALL,
  input  logic              MEM_LAM,
  input  logic              MEM_LAF,
  input  logic              MEM_SAM,
  input  logic              MEM_SAF,
  input  logic              TIMER,
  input  logic              EXTERNAL,
  input  logic              MIE,
  input  logic              PRIVILEGE,
  output logic [XLEN-1:0]   WB_RF_DATA,
  output logic              WB_LD_REG,
  output logic [REG_AW-1:0] WB_DRID_OUT,
  output logic [XLEN-1:0]   WB_CSR_DATA,
  output logic              WB_ST_CSR,
  output logic              WB_PC_MUX,
  output logic [XLEN-1:0]   WB_BR_JMP_TARGET,
  output logic [31:0]       WB_IR_OUT,
  output logic              WB_CS,
  output logic [XLEN-1:0]   WB_CAUSE,
  output logic [XLEN-1:0]   WB_EPC,
  output logic              WB_FLUSH,
  output logic              WB_STALL,
  output logic [CNT_W-1:0]  RETIRE_CNT
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state;
  logic [3:0]        drain_cnt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              writes_rd;
  logic              is_csr;
  logic [XLEN-1:0]   rd_data;
  logic              exc_hit;
  logic [3:0]        exc_code;
  logic              int_take;
  logic              take_trap;
  logic [XLEN-1:0]   trap_cause;

  assign opcode = WB_IR[6:0];
  assign funct3 = WB_IR[14:12];

  // Classify the instruction and pick the value destined for rd
  always_comb begin
    writes_rd = 1'b0;
    is_csr    = 1'b0;
    rd_data   = WB_ALU_RESULT;
    case (opcode)
      7'b0000011: begin
        writes_rd = 1'b1;
        rd_data   = WB_MEM_RESULT;
      end
      7'b0010011, 7'b0110011, 7'b0011011, 7'b0111011, 7'b0110111, 7'b0010111: begin
        writes_rd = 1'b1;
        rd_data   = WB_ALU_RESULT;
      end
      7'b1101111, 7'b1100111: begin
        writes_rd = 1'b1;
        rd_data   = WB_NPC;
      end
      7'b1110011: begin
        if (funct3 != 3'b000) begin
          writes_rd = 1'b1;
          is_csr    = 1'b1;
          rd_data   = WB_RFD;
        end
      end
      default: begin
        writes_rd = 1'b0;
      end
    endcase
  end

  // Pick the highest-priority exception and its cause code
  always_comb begin
    exc_hit  = 1'b1;
    exc_code = 4'd0;
    if (F_IAF)         exc_code = 4'd1;
    else if (F_IAM)    exc_code = 4'd0;
    else if (F_II)     exc_code = 4'd2;
    else if (WB_ECALL) exc_code = PRIVILEGE ? 4'd11 : 4'd8;
    else if (MEM_SAM)  exc_code = 4'd6;
    else if (MEM_LAM)  exc_code = 4'd4;
    else if (MEM_SAF)  exc_code = 4'd7;
    else if (MEM_LAF)  exc_code = 4'd5;
    else               exc_hit  = 1'b0;
  end

  assign int_take  = !exc_hit && (MIE || !PRIVILEGE) && (TIMER || EXTERNAL);
  assign take_trap = WB_V && (exc_hit || int_take);

  // Build the mcause value; interrupts set the top bit and external beats timer
  always_comb begin
    trap_cause = '0;
    if (exc_hit) begin
      trap_cause[3:0] = exc_code;
    end else begin
      trap_cause[XLEN-1] = 1'b1;
      trap_cause[3:0]    = EXTERNAL ? 4'd11 : 4'd7;
    end
  end

  // Commit/trap sequencer with registered outputs; DRAIN ignores all WB inputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state            <= RUN;
      drain_cnt        <= '0;
      WB_RF_DATA       <= '0;
      WB_LD_REG        <= 1'b0;
      WB_DRID_OUT      <= '0;
      WB_CSR_DATA      <= '0;
      WB_ST_CSR        <= 1'b0;
      WB_PC_MUX        <= 1'b0;
      WB_BR_JMP_TARGET <= '0;
      WB_IR_OUT        <= '0;
      WB_CS            <= 1'b0;
      WB_CAUSE         <= '0;
      WB_EPC           <= '0;
      WB_FLUSH         <= 1'b0;
      WB_STALL         <= 1'b0;
      RETIRE_CNT       <= '0;
    end else begin
      WB_LD_REG <= 1'b0;
      WB_ST_CSR <= 1'b0;
      WB_PC_MUX <= 1'b0;
      WB_CS     <= 1'b0;
      case (state)
        RUN: begin
          WB_FLUSH <= 1'b0;
          WB_STALL <= 1'b0;
          if (take_trap) begin
            WB_CS     <= 1'b1;
            WB_FLUSH  <= 1'b1;
            WB_STALL  <= 1'b1;
            WB_CAUSE  <= trap_cause;
            WB_EPC    <= WB_PC;
            drain_cnt <= 4'(TRAP_STALL - 1);
            state     <= DRAIN;
          end else if (WB_V) begin
            WB_IR_OUT        <= WB_IR;
            WB_DRID_OUT      <= WB_DRID;
            WB_BR_JMP_TARGET <= WB_ALU_RESULT;
            WB_PC_MUX        <= MEM_PC_MUX;
            RETIRE_CNT       <= RETIRE_CNT + CNT_W'(1);
            if (writes_rd) begin
              WB_RF_DATA <= rd_data;
              WB_LD_REG  <= (WB_DRID != '0);
            end
            if (is_csr) begin
              WB_CSR_DATA <= WB_CSRFD;
              WB_ST_CSR   <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state    <= RUN;
            WB_FLUSH <= 1'b0;
            WB_STALL <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: a 64-bit/64-bit-counter instance and a 32-bit/4-bit-counter
// instance share one stimulus stream and are compared against a behavioural model.
module tb_wb_commit_unit;

  localparam int TRAP_STALL = 2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_32    = 7'b0111011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  // exception flag vector order: {iaf, iam, ii, ecall, sam, lam, saf, laf}
  localparam logic [7:0] EX_NONE  = 8'h00;
  localparam logic [7:0] EX_IAM   = 8'h40;
  localparam logic [7:0] EX_II    = 8'h20;
  localparam logic [7:0] EX_ECALL = 8'h10;
  localparam logic [7:0] EX_LAF   = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_v;
  logic [31:0] wb_ir;
  logic [63:0] wb_pc, wb_npc, wb_mem, wb_alu, wb_rfd, wb_csrfd;
  logic [4:0]  wb_drid;
  logic        mem_pc_mux;
  logic        f_iaf, f_iam, f_ii, ecall, sam, lam, saf, laf;
  logic        timer, ext, mie, priv;

  logic [63:0] a_rf, a_csr, a_tgt, a_cause, a_epc, a_cnt;
  logic        a_ld, a_st, a_pcmux, a_cs, a_flush, a_stall;
  logic [4:0]  a_drid;
  logic [31:0] a_ir;

  logic [31:0] b_rf, b_csr, b_tgt, b_cause, b_epc;
  logic [3:0]  b_cnt;
  logic        b_ld, b_st, b_pcmux, b_cs, b_flush, b_stall;
  logic [4:0]  b_drid;
  logic [31:0] b_ir;

  logic [63:0] exp_rf, exp_csr, exp_tgt, exp_cause, exp_cause32, exp_epc, exp_cnt;
  logic        exp_ld, exp_st, exp_pcmux, exp_cs, exp_flush, exp_stall;
  logic [4:0]  exp_drid;
  logic [31:0] exp_ir;
  logic        committed;
  int          ignore_left;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_commit_unit #(.XLEN(64), .REG_AW(5), .TRAP_STALL(TRAP_STALL), .CNT_W(64)) dut64 (
    .CLK(clk), .RESET(rst_n), .WB_V(wb_v), .WB_IR(wb_ir), .WB_PC(wb_pc), .WB_NPC(wb_npc),
    .WB_MEM_RESULT(wb_mem), .WB_ALU_RESULT(wb_alu), .WB_RFD(wb_rfd), .WB_CSRFD(wb_csrfd),
    .WB_DRID(wb_drid), .MEM_PC_MUX(mem_pc_mux), .F_IAM(f_iam), .F_IAF(f_iaf), .F_II(f_ii),
    .WB_ECALL(ecall), .MEM_LAM(lam), .MEM_LAF(laf), .MEM_SAM(sam), .MEM_SAF(saf),
    .TIMER(timer), .EXTERNAL(ext), .MIE(mie), .PRIVILEGE(priv),
    .WB_RF_DATA(a_rf), .WB_LD_REG(a_ld), .WB_DRID_OUT(a_drid), .WB_CSR_DATA(a_csr),
    .WB_ST_CSR(a_st), .WB_PC_MUX(a_pcmux), .WB_BR_JMP_TARGET(a_tgt), .WB_IR_OUT(a_ir),
    .WB_CS(a_cs), .WB_CAUSE(a_cause), .WB_EPC(a_epc), .WB_FLUSH(a_flush), .WB_STALL(a_stall),
    .RETIRE_CNT(a_cnt)
  );

  wb_commit_unit #(.XLEN(32), .REG_AW(5), .TRAP_STALL(TRAP_STALL), .CNT_W(4)) dut32 (
    .CLK(clk), .RESET(rst_n), .WB_V(wb_v), .WB_IR(wb_ir), .WB_PC(wb_pc[31:0]), .WB_NPC(wb_npc[31:0]),
    .WB_MEM_RESULT(wb_mem[31:0]), .WB_ALU_RESULT(wb_alu[31:0]), .WB_RFD(wb_rfd[31:0]),
    .WB_CSRFD(wb_csrfd[31:0]), .WB_DRID(wb_drid), .MEM_PC_MUX(mem_pc_mux), .F_IAM(f_iam),
    .F_IAF(f_iaf), .F_II(f_ii), .WB_ECALL(ecall), .MEM_LAM(lam), .MEM_LAF(laf), .MEM_SAM(sam),
    .MEM_SAF(saf), .TIMER(timer), .EXTERNAL(ext), .MIE(mie), .PRIVILEGE(priv),
    .WB_RF_DATA(b_rf), .WB_LD_REG(b_ld), .WB_DRID_OUT(b_drid), .WB_CSR_DATA(b_csr),
    .WB_ST_CSR(b_st), .WB_PC_MUX(b_pcmux), .WB_BR_JMP_TARGET(b_tgt), .WB_IR_OUT(b_ir),
    .WB_CS(b_cs), .WB_CAUSE(b_cause), .WB_EPC(b_epc), .WB_FLUSH(b_flush), .WB_STALL(b_stall),
    .RETIRE_CNT(b_cnt)
  );

  // One comparison: counts it and reports tag/observed/expected on a miscompare
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Model reset: every output and the drain bookkeeping return to zero
  task automatic model_reset();
    exp_rf = '0; exp_csr = '0; exp_tgt = '0; exp_cause = '0; exp_cause32 = '0;
    exp_epc = '0; exp_cnt = '0; exp_ld = 0; exp_st = 0; exp_pcmux = 0; exp_cs = 0;
    exp_flush = 0; exp_stall = 0; exp_drid = '0; exp_ir = '0; committed = 0;
    ignore_left = 0;
  endtask

  // Reference behaviour for one clock edge, written from the commit/trap rules
  task automatic modelStep();
    logic [7:0] flags;
    int         causes[8];
    int         hit;
    logic       is_trap;
    logic [63:0] cause;
    logic [63:0] cause32;
    logic       wr;
    logic       csr;
    logic [63:0] data;
    committed = 0;
    exp_cs = 0; exp_ld = 0; exp_st = 0; exp_pcmux = 0;
    if (ignore_left > 0) begin
      ignore_left--;
      exp_flush = (ignore_left > 0);
      exp_stall = (ignore_left > 0);
    end else begin
      exp_flush = 0;
      exp_stall = 0;
      if (wb_v) begin
        flags  = {f_iaf, f_iam, f_ii, ecall, sam, lam, saf, laf};
        causes = '{1, 0, 2, (priv ? 11 : 8), 6, 4, 7, 5};
        hit = -1;
        for (int i = 0; i < 8; i++) if (hit < 0 && flags[7-i]) hit = i;
        is_trap = 1'b0;
        cause = '0;
        cause32 = '0;
        if (hit >= 0) begin
          is_trap = 1'b1;
          cause   = 64'(causes[hit]);
          cause32 = cause;
        end else if ((mie || !priv) && (timer || ext)) begin
          is_trap = 1'b1;
          cause   = 64'h8000_0000_0000_0000 + (ext ? 64'd11 : 64'd7);
          cause32 = 64'h0000_0000_8000_0000 + (ext ? 64'd11 : 64'd7);
        end
        if (is_trap) begin
          exp_cs = 1; exp_flush = 1; exp_stall = 1;
          exp_cause = cause; exp_cause32 = cause32; exp_epc = wb_pc;
          ignore_left = TRAP_STALL;
        end else begin
          wr = 0; csr = 0; data = '0;
          case (wb_ir[6:0])
            OP_LOAD: begin wr = 1; data = wb_mem; end
            OP_IMM, OP_REG, OP_IMM32, OP_32, OP_LUI, OP_AUIPC: begin wr = 1; data = wb_alu; end
            OP_JAL, OP_JALR: begin wr = 1; data = wb_npc; end
            OP_SYS: if (wb_ir[14:12] != 3'b000) begin wr = 1; csr = 1; data = wb_rfd; end
            default: wr = 0;
          endcase
          committed = 1;
          exp_cnt   = exp_cnt + 64'd1;
          exp_pcmux = mem_pc_mux;
          exp_tgt   = wb_alu;
          exp_ir    = wb_ir;
          if (wr) begin
            exp_rf   = data;
            exp_ld   = (wb_drid != 5'd0);
            exp_drid = wb_drid;
          end
          if (csr) begin
            exp_csr = wb_csrfd;
            exp_st  = 1;
          end
        end
      end
    end
  endtask

  // Compare both instances against the model
  task automatic checkOutput();
    chk("cs", {63'd0, a_cs}, {63'd0, exp_cs});
    chk("cs32", {63'd0, b_cs}, {63'd0, exp_cs});
    chk("flush", {63'd0, a_flush}, {63'd0, exp_flush});
    chk("flush32", {63'd0, b_flush}, {63'd0, exp_flush});
    chk("stall", {63'd0, a_stall}, {63'd0, exp_stall});
    chk("stall32", {63'd0, b_stall}, {63'd0, exp_stall});
    chk("ld_reg", {63'd0, a_ld}, {63'd0, exp_ld});
    chk("ld_reg32", {63'd0, b_ld}, {63'd0, exp_ld});
    chk("st_csr", {63'd0, a_st}, {63'd0, exp_st});
    chk("st_csr32", {63'd0, b_st}, {63'd0, exp_st});
    chk("pc_mux", {63'd0, a_pcmux}, {63'd0, exp_pcmux});
    chk("pc_mux32", {63'd0, b_pcmux}, {63'd0, exp_pcmux});
    chk("cause", a_cause, exp_cause);
    chk("cause32", {32'd0, b_cause}, exp_cause32);
    chk("epc", a_epc, exp_epc);
    chk("epc32", {32'd0, b_epc}, {32'd0, exp_epc[31:0]});
    chk("retire", a_cnt, exp_cnt);
    chk("retire32", {60'd0, b_cnt}, {60'd0, exp_cnt[3:0]});
    if (exp_ld) begin
      chk("rf_data", a_rf, exp_rf);
      chk("rf_data32", {32'd0, b_rf}, {32'd0, exp_rf[31:0]});
      chk("drid", {59'd0, a_drid}, {59'd0, exp_drid});
      chk("drid32", {59'd0, b_drid}, {59'd0, exp_drid});
    end
    if (exp_st) begin
      chk("csr_data", a_csr, exp_csr);
      chk("csr_data32", {32'd0, b_csr}, {32'd0, exp_csr[31:0]});
    end
    if (committed) begin
      chk("target", a_tgt, exp_tgt);
      chk("target32", {32'd0, b_tgt}, {32'd0, exp_tgt[31:0]});
      chk("ir_out", {32'd0, a_ir}, {32'd0, exp_ir});
      chk("ir_out32", {32'd0, b_ir}, {32'd0, exp_ir});
    end
  endtask

  // Every output of both instances must read zero while reset is held
  task automatic check_reset_zero();
    chk("rst_rf", a_rf, 0);        chk("rst_rf32", {32'd0, b_rf}, 0);
    chk("rst_ld", {63'd0, a_ld}, 0); chk("rst_ld32", {63'd0, b_ld}, 0);
    chk("rst_drid", {59'd0, a_drid}, 0);
    chk("rst_csr", a_csr, 0);      chk("rst_st", {63'd0, a_st}, 0);
    chk("rst_pcmux", {63'd0, a_pcmux}, 0);
    chk("rst_tgt", a_tgt, 0);      chk("rst_ir", {32'd0, a_ir}, 0);
    chk("rst_cs", {63'd0, a_cs}, 0);
    chk("rst_cause", a_cause, 0);  chk("rst_cause32", {32'd0, b_cause}, 0);
    chk("rst_epc", a_epc, 0);
    chk("rst_flush", {63'd0, a_flush}, 0); chk("rst_flush32", {63'd0, b_flush}, 0);
    chk("rst_stall", {63'd0, a_stall}, 0); chk("rst_stall32", {63'd0, b_stall}, 0);
    chk("rst_cnt", a_cnt, 0);      chk("rst_cnt32", {60'd0, b_cnt}, 0);
  endtask

  // Idle every WB input
  task automatic drive_idle();
    wb_v = 0; wb_ir = '0; wb_pc = '0; wb_npc = '0; wb_mem = '0; wb_alu = '0;
    wb_rfd = '0; wb_csrfd = '0; wb_drid = '0; mem_pc_mux = 0;
    {f_iaf, f_iam, f_ii, ecall, sam, lam, saf, laf} = 8'h00;
    timer = 0; ext = 0; mie = 0; priv = 1;
  endtask

  // Assert reset between clock edges, check outputs, release at the next falling edge
  task automatic pulse_reset();
    #2;
    rst_n = 0;
    drive_idle();
    #1;
    model_reset();
    check_reset_zero();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Drive one WB beat on the falling edge, then advance the model and compare
  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [63:0] pc, input logic [63:0] alu,
                               input logic [63:0] mem, input logic [63:0] rfd, input logic [63:0] csrfd,
                               input logic pcm, input logic [7:0] exc, input logic t, input logic e,
                               input logic m, input logic p);
    @(negedge clk);
    wb_v = v; wb_ir = {17'd0, f3, rd, op}; wb_pc = pc; wb_npc = pc + 64'd4;
    wb_alu = alu; wb_mem = mem; wb_rfd = rfd; wb_csrfd = csrfd; wb_drid = rd;
    mem_pc_mux = pcm;
    {f_iaf, f_iam, f_ii, ecall, sam, lam, saf, laf} = exc;
    timer = t; ext = e; mie = m; priv = p;
    @(posedge clk);
    #1;
    modelStep();
    checkOutput();
  endtask

  task automatic idle_step();
    applyStimulus(0, OP_IMM, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 0, EX_NONE, 0, 0, 1, 1);
  endtask

  // Directed scenarios followed by a randomized run
  initial begin
    logic [6:0] ops[13];
    ops = '{OP_LOAD, OP_IMM, OP_REG, OP_IMM32, OP_32, OP_LUI, OP_AUIPC,
            OP_JAL, OP_JALR, OP_SYS, OP_STORE, OP_BR, OP_FENCE};
    rst_n = 0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_zero();
    @(negedge clk);
    rst_n = 1;

    $display("[TB] reset mid-operation and first commit");
    applyStimulus(1, OP_IMM, 3'd0, 5'd7, 64'h10, 64'h99, 0, 0, 0, 0, EX_NONE, 0, 0, 1, 1);
    pulse_reset();
    applyStimulus(1, OP_IMM, 3'd0, 5'd5, 64'h20, 64'h1234, 0, 0, 0, 0, EX_NONE, 0, 0, 1, 1);
    chk("t1_rf", a_rf, 64'h1234);
    chk("t1_cnt", a_cnt, 64'd1);

    $display("[TB] x0 suppression and CSR write");
    applyStimulus(1, OP_LOAD, 3'd3, 5'd0, 64'h24, 64'h8, 64'hDEAD, 0, 0, 0, EX_NONE, 0, 0, 1, 1);
    chk("t2_ld_x0", {63'd0, a_ld}, 64'd0);
    applyStimulus(1, OP_SYS, 3'd1, 5'd3, 64'h28, 64'h0, 0, 64'hAA, 64'h55, 0, EX_NONE, 0, 0, 1, 1);
    chk("t2_rf", a_rf, 64'hAA);
    chk("t2_csr", a_csr, 64'h55);

    $display("[TB] jump redirect");
    applyStimulus(1, OP_JAL, 3'd0, 5'd1, 64'h100, 64'h200, 0, 0, 0, 1, EX_NONE, 0, 0, 1, 1);
    chk("t3_rf", a_rf, 64'h104);
    chk("t3_tgt", a_tgt, 64'h200);

    $display("[TB] exception priority and drain");
    applyStimulus(1, OP_LOAD, 3'd3, 5'd9, 64'h80, 64'h0, 0, 0, 0, 0, EX_II | EX_LAF, 0, 0, 1, 1);
    chk("t4_cause", a_cause, 64'd2);
    chk("t4_epc", a_epc, 64'h80);
    applyStimulus(1, OP_IMM, 3'd0, 5'd4, 64'h84, 64'h1, 0, 0, 0, 0, EX_ECALL, 1, 1, 1, 1);
    applyStimulus(1, OP_IMM, 3'd0, 5'd4, 64'h88, 64'h2, 0, 0, 0, 0, EX_ECALL, 1, 1, 1, 1);
    chk("t4_stall_end", {63'd0, a_stall}, 64'd0);
    applyStimulus(1, OP_IMM, 3'd0, 5'd4, 64'h8C, 64'h3, 0, 0, 0, 0, EX_NONE, 0, 0, 1, 1);

    $display("[TB] interrupts");
    applyStimulus(1, OP_IMM, 3'd0, 5'd6, 64'h90, 64'h4, 0, 0, 0, 0, EX_NONE, 1, 1, 1, 1);
    chk("t5_cause", a_cause, 64'h8000_0000_0000_000B);
    idle_step();
    idle_step();
    applyStimulus(1, OP_IMM, 3'd0, 5'd6, 64'h94, 64'h5, 0, 0, 0, 0, EX_NONE, 1, 1, 0, 1);
    chk("t5_masked", {63'd0, a_cs}, 64'd0);
    applyStimulus(1, OP_IMM, 3'd0, 5'd6, 64'h98, 64'h6, 0, 0, 0, 0, EX_NONE, 1, 0, 0, 0);
    chk("t5_user", {63'd0, a_cs}, 64'd1);
    idle_step();
    idle_step();

    $display("[TB] branch with exception, reset during drain");
    applyStimulus(1, OP_BR, 3'd0, 5'd0, 64'hA0, 64'h300, 0, 0, 0, 1, EX_IAM, 1, 0, 1, 1);
    chk("br_exc_pcmux", {63'd0, a_pcmux}, 64'd0);
    idle_step();
    pulse_reset();
    applyStimulus(1, OP_LUI, 3'd0, 5'd2, 64'hB0, 64'h7000, 0, 0, 0, 0, EX_NONE, 0, 0, 1, 1);

    $display("[TB] counter wrap and 32-bit interrupt cause");
    pulse_reset();
    for (int i = 0; i < 16; i++)
      applyStimulus(1, OP_IMM, 3'd0, 5'd1, 64'(i * 4), 64'(i), 0, 0, 0, 0, EX_NONE, 0, 0, 1, 1);
    chk("wrap_cnt32", {60'd0, b_cnt}, 64'd0);
    chk("wrap_cnt64", a_cnt, 64'd16);
    applyStimulus(1, OP_IMM, 3'd0, 5'd1, 64'hC0, 64'h0, 0, 0, 0, 0, EX_NONE, 1, 0, 1, 1);
    chk("t7_cause32", {32'd0, b_cause}, 64'h8000_0007);
    idle_step();
    idle_step();

    $display("[TB] randomized run");
    for (int n = 0; n < 400; n++) begin
      logic [7:0] exc;
      for (int k = 0; k < 8; k++) exc[k] = ($urandom_range(0, 15) == 0);
      applyStimulus(($urandom_range(0, 7) != 0), ops[$urandom_range(0, 12)], 3'($urandom),
                    5'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), exc,
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
Parametrised writeback/commit stage for the RISC-V core, successor to the fixed 64-bit writeback stage. Selects and registers register-file/CSR write data, steers branch/jump redirects, and arbitrates exceptions and interrupts into a single precise trap event. A trap sequencer flushes the pipe and stalls fetch for a programmable drain period. Sits after MEM; feeds the register file, the CSR file and the fetch PC mux.

Parameters:
XLEN, 64, datapath width; 32 or 64 only
REG_AW, 5, register index width
TRAP_STALL, 2, drain cycles after trap entry; legal range 1..15
CNT_W, 64, width of the retired-instruction counter

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous active-low reset
WB_V  in  1  valid instruction in WB
WB_IR  in  32  instruction word
WB_PC  in  XLEN  PC of the WB instruction
WB_NPC  in  XLEN  PC+4
WB_MEM_RESULT  in  XLEN  load data
WB_ALU_RESULT  in  XLEN  ALU result / branch target
WB_RFD  in  XLEN  old CSR value, destined for rd
WB_CSRFD  in  XLEN  new CSR value
WB_DRID  in  REG_AW  rd index
MEM_PC_MUX  in  1  branch/jump taken
F_IAM, F_IAF, F_II, WB_ECALL, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF  in  1 each  exception flags
TIMER, EXTERNAL  in  1 each  interrupt requests (level)
MIE  in  1  global machine interrupt enable
PRIVILEGE  in  1  1 = machine, 0 = user
WB_RF_DATA  out  XLEN  rd write data
WB_LD_REG  out  1  rd write enable
WB_DRID_OUT  out  REG_AW  rd index
WB_CSR_DATA  out  XLEN  CSR write data
WB_ST_CSR  out  1  CSR write enable
WB_PC_MUX  out  1  redirect fetch to WB_BR_JMP_TARGET
WB_BR_JMP_TARGET  out  XLEN  redirect target
WB_IR_OUT  out  32  committed instruction
WB_CS  out  1  one-cycle trap-entry pulse
WB_CAUSE  out  XLEN  mcause value
WB_EPC  out  XLEN  mepc value
WB_FLUSH  out  1  kill younger instructions
WB_STALL  out  1  hold fetch
RETIRE_CNT  out  CNT_W  committed-instruction count

Behaviour:
- Reset (RESET=0, async): every output 0, FSM=RUN, drain counter 0.
- All outputs registered; latency 1 cycle from WB inputs.
- FSM RUN: with WB_V=1, no exception and no taken interrupt, commit on the next edge.
  - LOAD 0000011: data = MEM_RESULT.
  - OP/OP-IMM/OP-32/OP-IMM-32, LUI, AUIPC: data = ALU_RESULT.
  - JAL/JALR: data = NPC.
  - SYSTEM 1110011 with funct3≠0: data = RFD; CSR_DATA = CSRFD; ST_CSR = 1.
  - Store/branch/other: no write.
  - LD_REG=1 only when the class writes and DRID≠0.
  - PC_MUX = MEM_PC_MUX; TARGET = ALU_RESULT.
  - RETIRE_CNT += 1 (wraps modulo 2^CNT_W).
- With WB_V=0: all enables/pulses are 0; data outputs hold their previous values.
- Enable outputs (LD_REG, ST_CSR, PC_MUX, CS, FLUSH) are single-cycle unless re-asserted.
- Exception priority (highest first), with cause:
  - F_IAF 1
  - F_IAM 0
  - F_II 2
  - ECALL (11 if PRIVILEGE else 8)
  - MEM_SAM 6
  - MEM_LAM 4
  - MEM_SAF 7
  - MEM_LAF 5
- Interrupt taken when WB_V=1, no exception, and (MIE | !PRIVILEGE):
  - EXTERNAL: cause = 2^(XLEN-1)+11.
  - TIMER: cause = 2^(XLEN-1)+7.
  - EXTERNAL wins if both are asserted.
- Trap (exception or interrupt):
  - Next edge: CS=1, FLUSH=1, CAUSE, EPC=WB_PC. No commit: LD_REG=ST_CSR=PC_MUX=0, RETIRE_CNT unchanged.
  - FSM → DRAIN.
- DRAIN: STALL=1, FLUSH=1 for TRAP_STALL cycles. All WB inputs are ignored, including exception and interrupt flags. Then FSM → RUN; STALL and FLUSH drop on the same edge.
- CAUSE/EPC hold until the next trap.
- Simultaneous exception and interrupt: exception wins; the interrupt stays pending at the source.
- Taken branch carrying an exception: trap only, PC_MUX=0.
- Reset asserted during DRAIN: immediate return to reset state.
- XLEN=32: all widths scale; the interrupt bit is bit 31.

Test Plan:
1. RESET low mid-operation → all outputs 0 within the same cycle. Release; ADDI x5 with ALU=0x1234 → next cycle LD_REG=1, DRID_OUT=5, RF_DATA=0x1234, RETIRE_CNT=1.
2. Writes to x0 are suppressed. Load to x0 → LD_REG=0, RETIRE_CNT increments. CSRRW x3 with RFD=0xAA, CSRFD=0x55 → RF_DATA=0xAA, CSR_DATA=0x55, LD_REG=ST_CSR=1.
3. JAL at PC 0x100, NPC=0x104, MEM_PC_MUX=1, ALU=0x200 → RF_DATA=0x104, PC_MUX=1, TARGET=0x200.
4. F_II and MEM_LAF together, WB_PC=0x80 → CS pulse, CAUSE=2, EPC=0x80, LD_REG=0. STALL=FLUSH=1 for exactly 2 cycles; ECALL inputs during drain are ignored.
5. TIMER and EXTERNAL, MIE=1, PRIVILEGE=1, XLEN=64 → CAUSE=0x800000000000000B. Same stimulus with MIE=0 → normal commit, no trap. With MIE=0 and PRIVILEGE=0 → trap taken.
6. Counter wrap with CNT_W=4: 16 commits → RETIRE_CNT=0.
7. XLEN=32, timer interrupt → CAUSE=0x80000007.
